// File: rtl/ldpc_pkg.sv
// Shared LDPC code geometry and error-checker FSM encoding, used by the decoder,
// the channel front-end and the error checker.
package ldpc_pkg;
   localparam int R       = 24;
   localparam int D       = 96;
   localparam int DIM     = R * D;
   localparam int CHUNK_W = 128;
   localparam int NCHUNK  = DIM / CHUNK_W;
   localparam int FRM_W   = 16;
   localparam int ERR_W   = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_REPORT = 2'd2
   } state_e;
endpackage

// File: rtl/ldpc_err_chk_if.sv
// Frame handshake and statistics bundle between the decoder side and the error checker.
interface ldpc_err_chk_if #(
   parameter int DIM   = ldpc_pkg::DIM,
   parameter int FRM_W = ldpc_pkg::FRM_W
);
   import ldpc_pkg::*;

   logic                 term;
   logic [DIM-1:0]       res;
   logic [DIM-1:0]       ref_cw;
   logic                 clr;
   logic                 ack;
   logic                 valid;
   logic [ERR_W-1:0]     errs;
   logic                 frm_err;
   logic [FRM_W-1:0]     frm_cnt;
   logic [FRM_W-1:0]     err_frm_cnt;
   logic                 busy;

   modport master (
      output term, res, ref_cw, clr,
      input  ack, valid, errs, frm_err, frm_cnt, err_frm_cnt, busy
   );

   modport slave (
      input  term, res, ref_cw, clr,
      output ack, valid, errs, frm_err, frm_cnt, err_frm_cnt, busy
   );
endinterface

// File: rtl/ldpc_err_chk_popcnt.sv
// Combinational population count of one codeword chunk.
module popcnt #(
   parameter int W = 128
) (
   input  logic [W-1:0]       data_i,
   output logic [$clog2(W):0] cnt_o
);
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) cnt_o = cnt_o + ($clog2(W)+1)'(data_i[i]);
   end
endmodule

// File: rtl/ldpc_err_chk.sv
// Bit-error checker: counts res ^ ref_cw one chunk per cycle after each decoded
// frame and keeps saturating frame / erroneous-frame statistics.
//
//   state     | meaning
//   ST_IDLE   | waiting for a term rising edge; captures the error vector
//   ST_COUNT  | accumulating popcount of one chunk per cycle
//   ST_REPORT | publishing errs/frm_err, bumping counters, pulsing valid/ack
module ldpc_err_chk #(
   parameter int R       = ldpc_pkg::R,
   parameter int D       = ldpc_pkg::D,
   parameter int CHUNK_W = ldpc_pkg::CHUNK_W,
   parameter int FRM_W   = ldpc_pkg::FRM_W
) (
   input  logic           clk,
   input  logic           rst,
   ldpc_err_chk_if.slave  bus
);
   import ldpc_pkg::*;

   localparam int DIM_L = R * D;
   localparam int NCH_L = DIM_L / CHUNK_W;
   localparam int IDX_W = $clog2(NCH_L + 1);
   localparam int PC_W  = $clog2(CHUNK_W) + 1;
   localparam logic [FRM_W-1:0] CNT_MAX = '1;

   state_e             state_q, state_d;
   logic               term_d_q;
   logic [DIM_L-1:0]   diff_q;
   logic [IDX_W-1:0]   idx_q;
   logic [ERR_W-1:0]   acc_q;
   logic [ERR_W-1:0]   errs_q;
   logic               frm_err_q;
   logic [FRM_W-1:0]   frm_cnt_q, err_frm_cnt_q;
   logic               valid_q, ack_q;

   logic               start, count_en, report, busy, last_chunk;
   logic [CHUNK_W-1:0] chunk;
   logic [PC_W-1:0]    chunk_cnt;

   assign last_chunk = (idx_q == IDX_W'(NCH_L - 1));
   assign chunk      = diff_q[int'(idx_q)*CHUNK_W +: CHUNK_W];

   popcnt #(.W(CHUNK_W)) u_popcnt (
      .data_i (chunk),
      .cnt_o  (chunk_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.term && !term_d_q) state_d = ST_COUNT;
         ST_COUNT:  if (last_chunk) state_d = ST_REPORT;
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      start    = 1'b0;
      count_en = 1'b0;
      report   = 1'b0;
      busy     = 1'b0;
      case (state_q)
         ST_IDLE:   start = bus.term && !term_d_q;
         ST_COUNT:  begin count_en = 1'b1; busy = 1'b1; end
         ST_REPORT: begin report = 1'b1; busy = 1'b1; end
         default:   ;
      endcase
   end

   // Snapshot of the error pattern; later res/ref_cw changes cannot disturb the frame.
   always_ff @(posedge clk) begin
      if (start) diff_q <= bus.res ^ bus.ref_cw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         term_d_q      <= 1'b0;
         idx_q         <= '0;
         acc_q         <= '0;
         errs_q        <= '0;
         frm_err_q     <= 1'b0;
         frm_cnt_q     <= '0;
         err_frm_cnt_q <= '0;
         valid_q       <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         term_d_q <= bus.term;
         valid_q  <= report;
         ack_q    <= report;
         if (start) begin
            idx_q <= '0;
            acc_q <= '0;
         end
         if (count_en) begin
            idx_q <= idx_q + 1'b1;
            acc_q <= acc_q + ERR_W'(chunk_cnt);
         end
         if (report) begin
            errs_q        <= acc_q;
            frm_err_q     <= (acc_q != '0);
            frm_cnt_q     <= frm_cnt_q + FRM_W'(frm_cnt_q != CNT_MAX);
            err_frm_cnt_q <= err_frm_cnt_q + FRM_W'((acc_q != '0) && (err_frm_cnt_q != CNT_MAX));
         end
         // A clear landing on the report cycle still discards that frame's count.
         if (bus.clr) begin
            frm_cnt_q     <= '0;
            err_frm_cnt_q <= '0;
         end
      end
   end

   assign bus.ack         = ack_q;
   assign bus.valid       = valid_q;
   assign bus.errs        = errs_q;
   assign bus.frm_err     = frm_err_q;
   assign bus.frm_cnt     = frm_cnt_q;
   assign bus.err_frm_cnt = err_frm_cnt_q;
   assign bus.busy        = busy;
endmodule

// File: tb/tb_ldpc_err_chk.sv
// Directed bench for ldpc_err_chk: frame expectations go into a scoreboard when a
// frame is launched and are popped by the monitor on each valid pulse.
module tb_ldpc_err_chk;
   import ldpc_pkg::*;

   // Narrow counters so saturation is reachable in a few frames.
   localparam int FRM_W_TB = 4;
   localparam int CMAX     = (1 << FRM_W_TB) - 1;

   typedef struct {
      int errs;
      int frm_err;
      int frm_cnt;
      int err_frm_cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ldpc_err_chk_if #(.DIM(DIM), .FRM_W(FRM_W_TB)) bus ();

   ldpc_err_chk #(.R(R), .D(D), .CHUNK_W(CHUNK_W), .FRM_W(FRM_W_TB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   int n_assert = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int m_frm    = 0;
   int m_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int e, input bit clr_rep);
      exp_t x;
      if (clr_rep) begin
         m_frm = 0;
         m_err = 0;
      end else begin
         if (m_frm < CMAX) m_frm++;
         if (e != 0 && m_err < CMAX) m_err++;
      end
      x.errs = e; x.frm_err = (e != 0); x.frm_cnt = m_frm; x.err_frm_cnt = m_err;
      sb.push_back(x);
   endtask

   function automatic logic [DIM-1:0] rand_vec();
      logic [DIM-1:0] v;
      for (int i = 0; i < DIM/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Called right after the edge that took the term rising edge (edge E).
   // valid is set by edge E+19 and is therefore captured downstream at edge E+20.
   task automatic wait_valid(input bit clr_rep);
      int k;
      k = 0;
      while (k < 40) begin
         @(posedge clk); k++; #1;
         if (k == 18 && clr_rep) bus.clr = 1'b1;
         if (k == 19) bus.clr = 1'b0;
         if (bus.valid) break;
      end
      chk("valid_latency", k, 19);
      @(posedge clk); #1;
      chk("valid_one_cycle", bus.valid, 0);
      chk("ack_one_cycle", bus.ack, 0);
      chk("busy_back_idle", bus.busy, 0);
   endtask

   task automatic run_frame(input logic [DIM-1:0] r, input logic [DIM-1:0] f,
                            input int exp_errs, input bit clr_rep, input bit scramble);
      @(negedge clk);
      bus.res = r; bus.ref_cw = f; bus.term = 1'b1;
      push_exp(exp_errs, clr_rep);
      @(posedge clk); #1;
      chk("busy_after_start", bus.busy, 1);
      bus.term = 1'b0;
      if (scramble) begin
         bus.res = rand_vec();
         bus.ref_cw = rand_vec();
      end
      wait_valid(clr_rep);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.valid || bus.ack)) begin
         n_valid++;
         chk("ack_with_valid", bus.ack, bus.valid);
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_valid: observed empty scoreboard expected a pending frame");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("errs", bus.errs, e.errs);
            chk("frm_err", bus.frm_err, e.frm_err);
            chk("frm_cnt", bus.frm_cnt, e.frm_cnt);
            chk("err_frm_cnt", bus.err_frm_cnt, e.err_frm_cnt);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, bus.valid, 0);
      chk({tag, "_ack"}, bus.ack, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_errs"}, bus.errs, 0);
      chk({tag, "_frm_err"}, bus.frm_err, 0);
      chk({tag, "_frm_cnt"}, bus.frm_cnt, 0);
      chk({tag, "_err_frm_cnt"}, bus.err_frm_cnt, 0);
   endtask

   initial begin
      logic [DIM-1:0] r, f, ones;
      int v0;

      rst = 1'b1;
      bus.term = 1'b0; bus.clr = 1'b0; bus.res = '0; bus.ref_cw = '0;
      ones = '1;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);

      // Clean frame.
      run_frame('0, '0, 0, 1'b0, 1'b0);

      // Chunk boundaries and the last codeword bit.
      r = '0; r[0] = 1'b1; r[127] = 1'b1; r[128] = 1'b1; r[DIM-1] = 1'b1;
      run_frame(r, '0, 4, 1'b0, 1'b0);

      // Clear in IDLE, then full-error frame and a matching random frame.
      @(negedge clk); bus.clr = 1'b1;
      m_frm = 0; m_err = 0;
      @(posedge clk); #1; bus.clr = 1'b0;
      chk("clr_idle_frm_cnt", bus.frm_cnt, 0);
      chk("clr_idle_err_frm_cnt", bus.err_frm_cnt, 0);
      run_frame(ones, '0, 2304, 1'b0, 1'b0);
      r = rand_vec();
      run_frame(r, r, 0, 1'b0, 1'b0);
      chk("two_frames_frm_cnt", bus.frm_cnt, 2);
      chk("two_frames_err_frm_cnt", bus.err_frm_cnt, 1);

      // Inputs changing after capture.
      r = rand_vec(); f = rand_vec();
      run_frame(r, f, $countones(r ^ f), 1'b0, 1'b1);

      // term held high with an extra pulse in COUNT cycle 5: one frame only.
      v0 = n_valid;
      @(negedge clk);
      r = '0; r[77] = 1'b1; r[2000] = 1'b1;
      bus.res = r; bus.ref_cw = '0; bus.term = 1'b1;
      push_exp(2, 1'b0);
      repeat (6) @(posedge clk);
      #1 bus.term = 1'b0;
      @(posedge clk); #1 bus.term = 1'b1;
      repeat (44) @(posedge clk);
      @(negedge clk); bus.term = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("held_term_pulses", n_valid - v0, 1);

      // Clear on the report cycle.
      r = '0; r[5] = 1'b1; r[600] = 1'b1; r[601] = 1'b1;
      run_frame(r, '0, 3, 1'b1, 1'b0);
      chk("clr_report_frm_cnt", bus.frm_cnt, 0);
      chk("clr_report_errs", bus.errs, 3);
      run_frame(ones, '0, 2304, 1'b0, 1'b0);

      // Reset in COUNT cycle 5 abandons the frame.
      v0 = n_valid;
      @(negedge clk);
      bus.res = ones; bus.ref_cw = '0; bus.term = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1; bus.term = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      m_frm = 0; m_err = 0;
      chk_all_zero("mid_rst");
      repeat (30) @(posedge clk);
      #1;
      chk("mid_rst_no_valid", n_valid - v0, 0);
      r = '0; r[1000] = 1'b1;
      run_frame(r, '0, 1, 1'b0, 1'b0);

      // term already high when reset releases counts as a rising edge.
      @(negedge clk);
      rst = 1'b1; bus.term = 1'b1; bus.res = '0; bus.ref_cw = '0; bus.ref_cw[9] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      m_frm = 0; m_err = 0;
      push_exp(1, 1'b0);
      @(posedge clk); #1;
      chk("post_rst_term_busy", bus.busy, 1);
      wait_valid(1'b0);
      @(negedge clk); bus.term = 1'b0;

      // Saturation of both counters.
      @(negedge clk); bus.clr = 1'b1;
      m_frm = 0; m_err = 0;
      @(posedge clk); #1 bus.clr = 1'b0;
      for (int i = 0; i < CMAX + 2; i++) run_frame(ones, '0, 2304, 1'b0, 1'b0);
      chk("sat_frm_cnt", bus.frm_cnt, CMAX);
      chk("sat_err_frm_cnt", bus.err_frm_cnt, CMAX);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no end of test expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ldpc_err_chk.md
LDPC_ERR_CHK -- requirements
Module: ldpc_err_chk

Interface
REQ-001 Parameter R, default 24, number of circulant columns in the base matrix.
REQ-002 Parameter D, default 96, circulant expansion factor; DIM = R*D = 2304 codeword bits.
REQ-003 Parameter CHUNK_W, default 128, bits compared per count cycle; DIM SHALL be a multiple of CHUNK_W, so NCHUNK = DIM/CHUNK_W = 18.
REQ-004 Parameter FRM_W, default 16, width of the frame statistics counters.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 term  input  1  decoder termination flag; a rising edge marks a valid decoded frame.
REQ-008 res  input  DIM  hard-decision decoded codeword; must be stable while term is high.
REQ-009 ref_cw  input  DIM  expected transmitted codeword; all-zero for the noise-only channel.
REQ-010 clr  input  1  synchronous clear of the frame statistics.
REQ-011 ack  output  1  one-cycle pulse releasing the upstream channel buffers for the next frame.
REQ-012 valid  output  1  one-cycle pulse; errs and frm_err are updated this cycle.
REQ-013 errs  output  12  bit-error count of the last frame.
REQ-014 frm_err  output  1  last frame had errs != 0.
REQ-015 frm_cnt  output  FRM_W  frames checked since reset or clr.
REQ-016 err_frm_cnt  output  FRM_W  erroneous frames since reset or clr.
REQ-017 busy  output  1  high in CAPTURE-through-REPORT (not IDLE).

Function
REQ-018 term SHALL be registered (term_d); a rising edge is term && !term_d, evaluated only in IDLE.
REQ-019 FSM states: IDLE, COUNT, REPORT.
REQ-020 IDLE: on a rising edge, diff <= res ^ ref_cw, chunk index <= 0, accumulator <= 0, go to COUNT.
REQ-021 COUNT: each cycle add popcount(diff[idx*CHUNK_W +: CHUNK_W]) to the accumulator and increment idx; after idx = NCHUNK-1 go to REPORT (exactly NCHUNK cycles in COUNT).
REQ-022 REPORT: register errs <= accumulator, frm_err <= (accumulator != 0), frm_cnt += 1, err_frm_cnt += frm_err; assert valid and ack; go to IDLE.
REQ-023 valid and ack are registered and SHALL be high exactly one cycle, NCHUNK+2 clocks after the edge that sampled the term rising edge (20 clocks with defaults).
REQ-024 The accumulator is 12 bits; DIM <= 4095 SHALL hold, so no overflow occurs.
REQ-025 frm_cnt and err_frm_cnt saturate at all-ones and do not wrap.
REQ-026 term rising edges while busy SHALL be ignored; term held high produces only one frame.
REQ-027 clr coincident with REPORT: the counters go to 0 (clr wins); errs and frm_err still update; valid and ack still pulse.
REQ-028 res and ref_cw changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-029 rst SHALL force: state IDLE; term_d, ack, valid, errs, frm_err, frm_cnt, err_frm_cnt, busy, idx, accumulator = 0.
REQ-030 rst mid-frame SHALL abandon the frame; no valid or ack is issued for it.
REQ-031 If term is already high on the first cycle after reset, it SHALL count as a rising edge.

Structure
REQ-032 Shared package ldpc_pkg SHALL hold R, D, DIM, CHUNK_W, NCHUNK and the FSM state enum, shared with the decoder and the channel front-end.
REQ-033 One sub-module, popcnt: combinational CHUNK_W-bit popcount with a $clog2(CHUNK_W)+1 output.

Verification
REQ-034 ref_cw=0, res=0, term rise -> 20 clocks later valid=ack=1 for one cycle, errs=0, frm_err=0, frm_cnt=1, err_frm_cnt=0.
REQ-035 res bits 0, 127, 128 and 2303 set -> errs=4, frm_err=1, err_frm_cnt=1.
REQ-036 res all ones, ref_cw=0 -> errs=2304; then res=ref_cw=random, second frame -> errs=0, frm_cnt=2, err_frm_cnt=1.
REQ-037 term held high 50 cycles, plus an extra pulse during COUNT cycle 5 -> exactly one valid/ack.
REQ-038 rst at COUNT cycle 5 -> no valid/ack afterwards, all outputs 0; next term rise completes normally.
REQ-039 clr in the REPORT cycle -> frm_cnt=0, err_frm_cnt=0, errs equals the frame's count.
